spinet_host: RTL and testbench

SPINET_HOST -- requirements
Module: spinet_host

---
 rtl/spinet_host.sv | 229 ++++++++++++++++++++++
 tb/tb_spinet_host.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spinet_host.sv
// spinet_host: SPI host that exchanges fixed-width packets with one spinet node.
//   wb_clk_i/wb_rst_i      : single clock, asynchronous active-high reset
//   tx_data/valid/ready    : push side of the TX FIFO (tx_ready = not full)
//   rx_data/valid/ready    : pop side of the RX FIFO (rx_data = head, combinational)
//   echo_en                : return valid received packets to their sender
//   sck/mosi/ss            : SPI host outputs (ss active-low)
//   miso/txrdy/rxrdy       : node outputs, asynchronous, synchronised internally
//   busy/overflow          : transaction in progress / sticky dropped-packet flag
module spinet_host #(
    parameter int W     = 16,
    parameter int AW    = 3,
    parameter int DEPTH = 4,
    parameter int DIV   = 4
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic [W-1:0] tx_data,
    input  logic         tx_valid,
    output logic         tx_ready,
    output logic [W-1:0] rx_data,
    output logic         rx_valid,
    input  logic         rx_ready,
    input  logic         echo_en,
    output logic         sck,
    output logic         mosi,
    output logic         ss,
    input  logic         miso,
    input  logic         txrdy,
    input  logic         rxrdy,
    output logic         busy,
    output logic         overflow
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int DCW = $clog2(DIV);
    localparam int BCW = $clog2(W);
    localparam logic [CW-1:0]  FIFO_FULL = CW'(DEPTH);
    localparam logic [DCW-1:0] DIV_LAST  = DCW'(DIV - 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(W - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    // Two-flop synchronisers for the node outputs
    logic [2:0] sync1_q, sync2_q;
    logic       miso_s, txrdy_s, rxrdy_s;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {miso, txrdy, rxrdy};
            sync2_q <= sync1_q;
        end
    end
    assign {miso_s, txrdy_s, rxrdy_s} = sync2_q;

    // FIFOs
    logic [W-1:0]  tx_mem_q [DEPTH];
    logic [W-1:0]  rx_mem_q [DEPTH];
    logic [PW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [PW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic          tx_push, tx_pop, rx_push, rx_pop;

    // Transaction state
    state_t         state_q, state_d;
    logic [DCW-1:0] div_q, div_d;
    logic [BCW-1:0] bit_q, bit_d;
    logic           phase_q, phase_d;
    logic [W-1:0]   sh_q, sh_d;
    logic [W-1:0]   echo_q, echo_d;
    logic           echo_full_q, echo_full_d;
    logic           ovf_q, ovf_d;
    logic [W-1:0]   rx_word, echo_word;
    logic           div_last, start;

    assign tx_ready = (tx_cnt_q != FIFO_FULL);
    assign rx_valid = (rx_cnt_q != '0);
    assign rx_data  = rx_mem_q[rx_rp_q];
    assign tx_push  = tx_valid && tx_ready;
    assign rx_pop   = rx_valid && rx_ready;

    assign start = (rx_cnt_q != FIFO_FULL) &&
                   (echo_full_q || ((tx_cnt_q != '0) && txrdy_s) || rxrdy_s);

    always_comb begin
        tx_wp_d  = tx_wp_q + PW'(tx_push);
        tx_rp_d  = tx_rp_q + PW'(tx_pop);
        tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        rx_wp_d  = rx_wp_q + PW'(rx_push);
        rx_rp_d  = rx_rp_q + PW'(rx_pop);
        rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    end

    always_ff @(posedge wb_clk_i) begin
        if (tx_push) tx_mem_q[tx_wp_q] <= tx_data;
        if (rx_push) rx_mem_q[rx_wp_q] <= rx_word;
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        phase_d     = phase_q;
        sh_d        = sh_q;
        echo_d      = echo_q;
        echo_full_d = echo_full_q;
        ovf_d       = ovf_q;
        tx_pop      = 1'b0;
        rx_push     = 1'b0;
        div_last    = (div_q == DIV_LAST);
        // Word as it stands after the current miso sample is shifted in
        rx_word     = {sh_q[W-2:0], miso_s};
        echo_word   = rx_word;
        echo_word[W-3 -: AW]    = rx_word[W-3-AW -: AW];
        echo_word[W-3-AW -: AW] = rx_word[W-3 -: AW];

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    div_d   = '0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                    if (echo_full_q) begin
                        sh_d        = echo_q;
                        echo_full_d = 1'b0;
                    end else if ((tx_cnt_q != '0) && txrdy_s) begin
                        sh_d   = tx_mem_q[tx_rp_q];
                        tx_pop = 1'b1;
                    end else begin
                        sh_d = '0;
                    end
                end
            end
            SETUP: begin
                div_d = div_q + 1'b1;
                if (div_last) begin
                    div_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                div_d = div_q + 1'b1;
                if (div_last) begin
                    div_d   = '0;
                    phase_d = ~phase_q;
                    // End of the sck-high half: sample and move to next bit
                    if (phase_q) begin
                        sh_d  = rx_word;
                        bit_d = bit_q + 1'b1;
                        if (bit_q == BIT_LAST) begin
                            state_d = HOLD;
                            bit_d   = '0;
                            if (rx_word[W-1]) begin
                                if (echo_en) begin
                                    echo_d      = echo_word;
                                    echo_full_d = 1'b1;
                                end else if ((rx_cnt_q == FIFO_FULL) && !rx_pop) begin
                                    ovf_d = 1'b1;
                                end else begin
                                    rx_push = 1'b1;
                                end
                            end
                        end
                    end
                end
            end
            HOLD: begin
                div_d = div_q + 1'b1;
                if (div_last) begin
                    div_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                div_d = div_q + 1'b1;
                if (div_last) begin
                    div_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            phase_q     <= 1'b0;
            sh_q        <= '0;
            echo_q      <= '0;
            echo_full_q <= 1'b0;
            ovf_q       <= 1'b0;
            tx_wp_q     <= '0;
            tx_rp_q     <= '0;
            tx_cnt_q    <= '0;
            rx_wp_q     <= '0;
            rx_rp_q     <= '0;
            rx_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            phase_q     <= phase_d;
            sh_q        <= sh_d;
            echo_q      <= echo_d;
            echo_full_q <= echo_full_d;
            ovf_q       <= ovf_d;
            tx_wp_q     <= tx_wp_d;
            tx_rp_q     <= tx_rp_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_wp_q     <= rx_wp_d;
            rx_rp_q     <= rx_rp_d;
            rx_cnt_q    <= rx_cnt_d;
        end
    end

    // Outputs decode straight from state so reset reaches the pins asynchronously
    assign ss       = (state_q == IDLE) || (state_q == GAP);
    assign sck      = (state_q == SHIFT) && phase_q;
    assign mosi     = ((state_q == SETUP) || (state_q == SHIFT)) && sh_q[W-1];
    assign busy     = (state_q != IDLE);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_spinet_host.sv
module tb_spinet_host;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic         echo_en;
    logic         sck, mosi, ss;
    logic         miso = 1'b0;
    logic         txrdy, rxrdy;
    logic         busy, overflow;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_mosi_q[$];
    logic [W-1:0] exp_rx_q[$];

    // Node model and bus monitor state
    logic [W-1:0] node_word = '0;
    logic [W-1:0] nsh       = '0;
    logic [W-1:0] mosi_cap  = '0;
    logic         prev_sck  = 1'b0;
    logic         prev_ss   = 1'b1;
    logic         prev_busy = 1'b0;
    int           sck_rises  = 0;
    int           sckhi_tot  = 0;
    int           txn_starts = 0;

    always #5 clk = ~clk;

    spinet_host #(.W(16), .AW(3), .DEPTH(4), .DIV(4)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .echo_en  (echo_en),
        .sck      (sck),
        .mosi     (mosi),
        .ss       (ss),
        .miso     (miso),
        .txrdy    (txrdy),
        .rxrdy    (rxrdy),
        .busy     (busy),
        .overflow (overflow)
    );

    // Node: presents its word MSB first from ss fall, advancing on each sck fall.
    always @(negedge clk) begin
        if (sck === 1'b1) sckhi_tot <= sckhi_tot + 1;
        if (sck === 1'b1 && prev_sck === 1'b0) begin
            sck_rises <= sck_rises + 1;
            mosi_cap  <= {mosi_cap[W-2:0], mosi};
        end
        if (busy === 1'b1 && prev_busy === 1'b0) txn_starts <= txn_starts + 1;
        if (ss === 1'b0 && prev_ss === 1'b1) begin
            nsh  <= node_word << 1;
            miso <= node_word[W-1];
        end else if (ss === 1'b0 && sck === 1'b0 && prev_sck === 1'b1) begin
            nsh  <= nsh << 1;
            miso <= nsh[W-1];
        end
        prev_sck  <= sck;
        prev_ss   <= ss;
        prev_busy <= busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_mosi(input string tag);
        logic [W-1:0] e = 'x;
        if (exp_mosi_q.size() > 0) e = exp_mosi_q.pop_front();
        check(tag, mosi_cap, e);
    endtask

    task automatic pop_rx(input string tag);
        logic [W-1:0] e = 'x;
        if (exp_rx_q.size() > 0) e = exp_rx_q.pop_front();
        check({tag, "_valid"}, rx_valid, 1);
        check(tag, rx_data, e);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    // Waits (bounded) for a transaction to start and end; len = busy cycles.
    task automatic wait_txn(input string tag, output int len);
        int n = 0;
        len = 0;
        while (busy !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_start"}, busy, 1);
        while (busy === 1'b1 && len < 400) begin
            len++;
            @(negedge clk);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int s0;
        int h0;
        int n;

        rst = 1'b1; tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;
        echo_en = 1'b0; txrdy = 1'b0; rxrdy = 1'b0;
        #1;
        check("rst_ss", ss, 1);
        check("rst_sck", sck, 0);
        check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // TX-only transaction, node returns zero
        txrdy = 1'b1;
        repeat (3) @(negedge clk);
        node_word = 16'h0000;
        tx_data = 16'h8941; tx_valid = 1'b1;
        exp_mosi_q.push_back(16'h8941);
        @(negedge clk);
        tx_valid = 1'b0;
        s0 = sck_rises; h0 = sckhi_tot;
        wait_txn("tx8941", len);
        check("tx_len", len, 140);
        check("tx_sck_pulses", sck_rises - s0, 16);
        check("tx_sck_high", sckhi_tot - h0, 64);
        check_mosi("tx_mosi");
        check("tx_rx_empty", rx_valid, 0);
        check("tx_overflow", overflow, 0);
        check("tx_ready_after", tx_ready, 1);

        // Node-initiated receive, queued
        txrdy = 1'b0; echo_en = 1'b0;
        repeat (3) @(negedge clk);
        node_word = 16'h8A40;
        exp_mosi_q.push_back(16'h0000);
        exp_rx_q.push_back(16'h8A40);
        rxrdy = 1'b1;
        @(negedge clk);
        rxrdy = 1'b0;
        wait_txn("rx8a40", len);
        check("rx_len", len, 140);
        check_mosi("rx_mosi_zero");
        pop_rx("rx_data");
        check("rx_drained", rx_valid, 0);

        // Echo: received word returned with dest/src swapped
        echo_en = 1'b1;
        node_word = 16'h8A40;
        exp_mosi_q.push_back(16'h0000);
        rxrdy = 1'b1;
        @(negedge clk);
        rxrdy = 1'b0;
        wait_txn("echo_in", len);
        check_mosi("echo_in_mosi");
        check("echo_rx_empty", rx_valid, 0);
        node_word = 16'h0000;
        echo_en = 1'b0;
        exp_mosi_q.push_back(16'h9140);
        wait_txn("echo_out", len);
        check("echo_len", len, 140);
        check_mosi("echo_out_mosi");
        check("echo_rx_still_empty", rx_valid, 0);
        check("echo_overflow", overflow, 0);

        // TX FIFO fill; a push while full is ignored
        for (int i = 0; i < 5; i++) begin
            tx_data = 16'hA001 + 16'(i);
            tx_valid = 1'b1;
            if (i < 4) exp_mosi_q.push_back(16'hA001 + 16'(i));
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check("txfull_ready", tx_ready, 0);
        txrdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_txn("txq", len);
            check_mosi("txq_mosi");
        end
        s0 = txn_starts;
        repeat (60) @(negedge clk);
        check("txq_no_extra", txn_starts - s0, 0);
        check("txq_ready", tx_ready, 1);
        txrdy = 1'b0;

        // RX fill to DEPTH blocks new transactions; one pop admits exactly one
        node_word = 16'h8001;
        for (int i = 0; i < 4; i++) begin
            exp_rx_q.push_back(16'h8001 + 16'(i));
            exp_mosi_q.push_back(16'h0000);
        end
        rxrdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_txn("fill", len);
            check_mosi("fill_mosi");
            node_word = 16'h8002 + 16'(i);
        end
        s0 = txn_starts;
        repeat (60) @(negedge clk);
        check("full_no_txn", txn_starts - s0, 0);
        check("full_busy", busy, 0);
        exp_rx_q.push_back(16'h8005);
        exp_mosi_q.push_back(16'h0000);
        s0 = txn_starts;
        pop_rx("fill_pop0");
        repeat (200) @(negedge clk);
        check("one_txn_after_pop", txn_starts - s0, 1);
        check_mosi("refill_mosi");
        rxrdy = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 4; i++) pop_rx("drain");
        check("drain_empty", rx_valid, 0);
        check("fill_overflow", overflow, 0);

        // Reset during bit 7 of SHIFT aborts the transaction
        node_word = 16'h8123;
        txrdy = 1'b1;
        repeat (3) @(negedge clk);
        tx_data = 16'hFFFF; tx_valid = 1'b1;
        s0 = sck_rises;
        @(negedge clk);
        tx_valid = 1'b0;
        n = 0;
        while (sck_rises - s0 < 8 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("abort_at_bit7", sck_rises - s0, 8);
        check("abort_sck_high", sck, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_ss", ss, 1);
        check("abort_sck", sck, 0);
        check("abort_mosi", mosi, 0);
        check("abort_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        txrdy = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_rx_empty", rx_valid, 0);
        check("abort_tx_ready", tx_ready, 1);
        check("abort_idle", busy, 0);
        check("abort_overflow", overflow, 0);

        check("scoreboard_drained", exp_mosi_q.size() + exp_rx_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
